// File: rtl/pcie_phy_pkg.sv
// Shared types and constants for the PHY transmit path.
package pcie_phy_pkg;

    // Arbiter FSM states: idle arbitration cycle, or locked to one source.
    typedef enum logic [1:0] {
        TX_ARB_IDLE = 2'd0,
        TX_ARB_DLLP = 2'd1,
        TX_ARB_TLP  = 2'd2
    } tx_arb_state_e;

    // tuser bit carrying the packet type towards the framer (1 = TLP, 0 = DLLP).
    localparam int TX_TUSER_TLP_BIT = 0;

endpackage

// File: rtl/axis_skid_buffer.sv
// AXI-Stream register slice: registered outputs plus one skid entry so the
// upstream sees a registered tready and throughput stays at one beat/cycle.
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready
);

    logic                  skid_valid_q;
    logic [DATA_WIDTH-1:0] skid_tdata_q;
    logic [KEEP_WIDTH-1:0] skid_tkeep_q;
    logic                  skid_tlast_q;
    logic [USER_WIDTH-1:0] skid_tuser_q;

    logic out_free;
    logic in_fire;

    // Upstream may push whenever the skid entry is free.
    assign s_axis_tready = !skid_valid_q;
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign in_fire       = s_axis_tvalid && !skid_valid_q;

    // Output register and skid occupancy: refill output from skid first, else from input.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            skid_valid_q  <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= skid_tdata_q;
                m_axis_tkeep  <= skid_tkeep_q;
                m_axis_tlast  <= skid_tlast_q;
                m_axis_tuser  <= skid_tuser_q;
                skid_valid_q  <= 1'b0;
            end else if (in_fire) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tkeep  <= s_axis_tkeep;
                m_axis_tlast  <= s_axis_tlast;
                m_axis_tuser  <= s_axis_tuser;
            end else begin
                m_axis_tvalid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
        end
    end

    // Skid payload capture when the output is stalled.
    always_ff @(posedge clk_i) begin
        // NOTE: payload-only registers carry no reset; skid_valid_q qualifies them.
        if (!out_free && in_fire) begin
            skid_tdata_q <= s_axis_tdata;
            skid_tkeep_q <= s_axis_tkeep;
            skid_tlast_q <= s_axis_tlast;
            skid_tuser_q <= s_axis_tuser;
        end
    end

endmodule

// File: rtl/tx_packet_arbiter.sv
// Packet-boundary arbiter merging the DLLP and TLP streams for the PHY TX framer.
// DLLPs win ties; the packet type is tagged into tuser. Output via axis_skid_buffer.
// Optional build macro TX_ARB_STARVE_GUARD_EN enables the TLP starvation guard.
module tx_packet_arbiter
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 5,
    parameter int MAX_DLLP_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] s_tlp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tlp_axis_tkeep,
    input  logic                  s_tlp_axis_tvalid,
    input  logic                  s_tlp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_tlp_axis_tuser,
    output logic                  s_tlp_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_dllp_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_dllp_axis_tkeep,
    input  logic                  s_dllp_axis_tvalid,
    input  logic                  s_dllp_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_dllp_axis_tuser,
    output logic                  s_dllp_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  grant_tlp_o
);

    if (MAX_DLLP_BURST < 1) begin : g_param_check
        $error("MAX_DLLP_BURST must be at least 1");
    end

    tx_arb_state_e state_q, state_d;

    logic                  skid_ready;
    logic                  tlp_fire, dllp_fire;
    logic                  guard_take_tlp;
    logic                  grant_tlp_q;
    logic                  mux_valid, mux_last;
    logic [DATA_WIDTH-1:0] mux_data;
    logic [KEEP_WIDTH-1:0] mux_keep;
    logic [USER_WIDTH-1:0] mux_user;

    assign s_tlp_axis_tready  = (state_q == TX_ARB_TLP)  && skid_ready;
    assign s_dllp_axis_tready = (state_q == TX_ARB_DLLP) && skid_ready;
    assign tlp_fire           = s_tlp_axis_tvalid  && s_tlp_axis_tready;
    assign dllp_fire          = s_dllp_axis_tvalid && s_dllp_axis_tready;
    assign grant_tlp_o        = grant_tlp_q;

`ifdef TX_ARB_STARVE_GUARD_EN
    localparam int BURST_W = $clog2(MAX_DLLP_BURST + 1);
    logic [BURST_W-1:0] burst_cnt_q;

    // Count DLLP packets that completed while a TLP was waiting; saturate at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            burst_cnt_q <= '0;
        end else if (tlp_fire && s_tlp_axis_tlast) begin
            burst_cnt_q <= '0;
        end else if (dllp_fire && s_dllp_axis_tlast) begin
            if (!s_tlp_axis_tvalid) begin
                burst_cnt_q <= '0;
            end else if (burst_cnt_q != BURST_W'(MAX_DLLP_BURST)) begin
                burst_cnt_q <= burst_cnt_q + 1'b1;
            end
        end
    end

    assign guard_take_tlp = (burst_cnt_q == BURST_W'(MAX_DLLP_BURST)) && s_tlp_axis_tvalid;
`else
    assign guard_take_tlp = 1'b0;
`endif

    // State register and sticky packet-type flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= TX_ARB_IDLE;
            grant_tlp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == TX_ARB_IDLE && state_d == TX_ARB_TLP) begin
                grant_tlp_q <= 1'b1;
            end else if (state_q == TX_ARB_IDLE && state_d == TX_ARB_DLLP) begin
                grant_tlp_q <= 1'b0;
            end
        end
    end

    // Next-state: grant only from IDLE, release after the granted source's tlast.
    always_comb begin
        // NOTE: default assignment first keeps every path driven, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            TX_ARB_IDLE: begin
                if (link_up_i) begin
                    if (guard_take_tlp) begin
                        state_d = TX_ARB_TLP;
                    end else if (s_dllp_axis_tvalid) begin
                        state_d = TX_ARB_DLLP;
                    end else if (s_tlp_axis_tvalid) begin
                        state_d = TX_ARB_TLP;
                    end
                end
            end
            TX_ARB_DLLP: if (dllp_fire && s_dllp_axis_tlast) state_d = TX_ARB_IDLE;
            TX_ARB_TLP:  if (tlp_fire && s_tlp_axis_tlast)   state_d = TX_ARB_IDLE;
            default:     state_d = TX_ARB_IDLE;
        endcase
    end

    // Source mux into the output stage with the packet-type bit forced.
    always_comb begin
        mux_valid = 1'b0;
        mux_data  = '0;
        mux_keep  = '0;
        mux_last  = 1'b0;
        mux_user  = '0;
        unique case (state_q)
            TX_ARB_DLLP: begin
                mux_valid = s_dllp_axis_tvalid;
                mux_data  = s_dllp_axis_tdata;
                mux_keep  = s_dllp_axis_tkeep;
                mux_last  = s_dllp_axis_tlast;
                mux_user  = s_dllp_axis_tuser;
            end
            TX_ARB_TLP: begin
                mux_valid = s_tlp_axis_tvalid;
                mux_data  = s_tlp_axis_tdata;
                mux_keep  = s_tlp_axis_tkeep;
                mux_last  = s_tlp_axis_tlast;
                mux_user  = s_tlp_axis_tuser;
            end
            default: ;
        endcase
        mux_user[TX_TUSER_TLP_BIT] = (state_q == TX_ARB_TLP);
    end

    axis_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .USER_WIDTH (USER_WIDTH)
    ) u_out_stage (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_axis_tdata  (mux_data),
        .s_axis_tkeep  (mux_keep),
        .s_axis_tvalid (mux_valid),
        .s_axis_tlast  (mux_last),
        .s_axis_tuser  (mux_user),
        .s_axis_tready (skid_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

endmodule
